// File: rtl/so_pkg.sv
// ---------------------------------------------------------------------------
// so_pkg
// Shared definitions for the OS-side loader blocks: the loader state
// encoding, default word/address/HD field widths and the instruction
// memory size. Imported by carregador_hd_mi and contador_trilha_setor.
// ---------------------------------------------------------------------------
package so_pkg;

  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 6;
  localparam int SETOR_W     = 6;
  localparam int TRILHA_W    = 4;
  localparam int MI_PALAVRAS = 64;

  // Loader states: waiting, reading one HD word, writing it to the
  // instruction memory, and the one-cycle completion state.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LER     = 2'd1,
    ESCREVE = 2'd2,
    FIM     = 2'd3
  } estado_t;

endpackage : so_pkg

// File: rtl/contador_trilha_setor.sv
// ---------------------------------------------------------------------------
// contador_trilha_setor
// Loadable {trilha,setor} HD address register. Incrementing moves to the
// next sector; when the sector wraps to zero the track advances, and the
// track itself wraps silently.
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-high reset, clears both fields
//   load_i        load trilha_ini_i/setor_ini_i (has priority over inc_i)
//   inc_i         advance to the next sector
//   trilha_ini_i  track value to load
//   setor_ini_i   sector value to load
//   trilha_o      current track (registered)
//   setor_o       current sector (registered)
// ---------------------------------------------------------------------------
module contador_trilha_setor #(
  parameter int TRILHA_W = so_pkg::TRILHA_W,
  parameter int SETOR_W  = so_pkg::SETOR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  logic                inc_i,
  input  logic [TRILHA_W-1:0] trilha_ini_i,
  input  logic [SETOR_W-1:0]  setor_ini_i,
  output logic [TRILHA_W-1:0] trilha_o,
  output logic [SETOR_W-1:0]  setor_o
);

  import so_pkg::*;

  logic [TRILHA_W-1:0] trilha_q, trilha_d;
  logic [SETOR_W-1:0]  setor_q,  setor_d;

  // Next address: load wins over increment; the track only moves when the
  // sector is about to roll over from its all-ones value.
  always_comb begin
    trilha_d = trilha_q;
    setor_d  = setor_q;
    if (load_i) begin
      trilha_d = trilha_ini_i;
      setor_d  = setor_ini_i;
    end else if (inc_i) begin
      setor_d = setor_q + SETOR_W'(1);
      if (setor_q == '1) begin
        trilha_d = trilha_q + TRILHA_W'(1);
      end
    end
  end

  // Address register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trilha_q <= '0;
      setor_q  <= '0;
    end else begin
      trilha_q <= trilha_d;
      setor_q  <= setor_d;
    end
  end

  assign trilha_o = trilha_q;
  assign setor_o  = setor_q;

endmodule : contador_trilha_setor

// File: rtl/carregador_hd_mi.sv
// ---------------------------------------------------------------------------
// carregador_hd_mi
// Copies a block of words from the HD into instruction memory while the CPU
// is held. Each word takes HD_LAT cycles in LER (waiting for the HD read)
// followed by one ESCREVE cycle that writes it. A request that is empty or
// would run past the end of instruction memory is rejected with an erro
// pulse and causes no HD or memory activity.
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-high reset
//   start         transfer request, sampled only in IDLE
//   trilha_ini    first HD track
//   setor_ini     first HD sector
//   dest_ini      first instruction-memory address
//   num_palavras  number of words, 0..64
//   hd_trilha     HD track address (registered)
//   hd_setor      HD sector address (registered)
//   hd_dado       HD read data, valid HD_LAT cycles after the address
//   mi_ender      instruction-memory write address
//   mi_dado       instruction-memory write data
//   mi_we         instruction-memory write enable
//   bloq_cpu      CPU hold, high in LER and ESCREVE
//   busy          high in every state except IDLE
//   done          one-cycle pulse when the transfer completes
//   erro          one-cycle pulse when a request is rejected
// ---------------------------------------------------------------------------
module carregador_hd_mi #(
  parameter int DATA_W   = so_pkg::DATA_W,
  parameter int ADDR_W   = so_pkg::ADDR_W,
  parameter int SETOR_W  = so_pkg::SETOR_W,
  parameter int TRILHA_W = so_pkg::TRILHA_W,
  parameter int HD_LAT   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [TRILHA_W-1:0] trilha_ini,
  input  logic [SETOR_W-1:0]  setor_ini,
  input  logic [ADDR_W-1:0]   dest_ini,
  input  logic [ADDR_W:0]     num_palavras,
  output logic [TRILHA_W-1:0] hd_trilha,
  output logic [SETOR_W-1:0]  hd_setor,
  input  logic [DATA_W-1:0]   hd_dado,
  output logic [ADDR_W-1:0]   mi_ender,
  output logic [DATA_W-1:0]   mi_dado,
  output logic                mi_we,
  output logic                bloq_cpu,
  output logic                busy,
  output logic                done,
  output logic                erro
);

  import so_pkg::*;

  // The wait counter needs at least one bit even when HD_LAT is 1.
  localparam int              WAIT_W   = (HD_LAT > 1) ? $clog2(HD_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_ULT = WAIT_W'(HD_LAT - 1);

  estado_t             state_q, state_d;
  logic [WAIT_W-1:0]   wait_q,  wait_d;
  logic [ADDR_W-1:0]   dest_q,  dest_d;
  logic [ADDR_W:0]     rem_q,   rem_d;
  logic [DATA_W-1:0]   buf_q,   buf_d;
  logic                erro_q,  erro_d;

  logic                cnt_load;
  logic                cnt_inc;
  logic                rejeita;
  logic [ADDR_W:0]     fim_bloco;

  // One past the last destination address; it may equal the memory size
  // exactly but must not exceed it. The sum fits in ADDR_W+1 bits.
  assign fim_bloco = {1'b0, dest_ini} + num_palavras;
  assign rejeita   = (num_palavras == '0) ||
                     (fim_bloco > (ADDR_W+1)'(MI_PALAVRAS));

  contador_trilha_setor #(
    .TRILHA_W (TRILHA_W),
    .SETOR_W  (SETOR_W)
  ) u_contador (
    .clk          (clk),
    .reset        (reset),
    .load_i       (cnt_load),
    .inc_i        (cnt_inc),
    .trilha_ini_i (trilha_ini),
    .setor_ini_i  (setor_ini),
    .trilha_o     (hd_trilha),
    .setor_o      (hd_setor)
  );

  // Next-state logic. The HD address advances at the end of each ESCREVE so
  // the following LER already presents the next sector; after the last word
  // it also advances, which is harmless because nothing reads it.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    dest_d   = dest_q;
    rem_d    = rem_q;
    buf_d    = buf_q;
    erro_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (rejeita) begin
            erro_d = 1'b1;
          end else begin
            cnt_load = 1'b1;
            dest_d   = dest_ini;
            rem_d    = num_palavras;
            wait_d   = '0;
            state_d  = LER;
          end
        end
      end
      LER: begin
        if (wait_q == WAIT_ULT) begin
          buf_d   = hd_dado;
          wait_d  = '0;
          state_d = ESCREVE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ESCREVE: begin
        dest_d  = dest_q + ADDR_W'(1);
        rem_d   = rem_q - (ADDR_W+1)'(1);
        cnt_inc = 1'b1;
        state_d = (rem_q == (ADDR_W+1)'(1)) ? FIM : LER;
      end
      FIM: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      dest_q  <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      dest_q  <= dest_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
      erro_q  <= erro_d;
    end
  end

  // Control outputs decode the state directly so an asynchronous reset
  // drops the write enable and the CPU hold without waiting for a clock.
  assign mi_we    = (state_q == ESCREVE);
  assign mi_ender = dest_q;
  assign mi_dado  = buf_q;
  assign bloq_cpu = (state_q == LER) || (state_q == ESCREVE);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIM);
  assign erro     = erro_q;

endmodule : carregador_hd_mi

// File: tb/tb_carregador_hd_mi.sv
// ---------------------------------------------------------------------------
// tb_carregador_hd_mi
// Directed bench for carregador_hd_mi. Two instances are built, one with
// HD_LAT=1 and one with HD_LAT=3, each with its own HD model that returns
// a pattern derived from the {trilha,setor} it was addressed with.
// ---------------------------------------------------------------------------
module tb_carregador_hd_mi;

  logic        clk;
  logic        reset;
  logic        start1;
  logic        start3;
  logic [3:0]  trilhaIni;
  logic [5:0]  setorIni;
  logic [5:0]  destIni;
  logic [6:0]  numPalavras;

  logic [3:0]  hdT1, hdT3;
  logic [5:0]  hdS1, hdS3;
  logic [31:0] hdDado1, hdDado3;
  logic [5:0]  ender1, ender3;
  logic [31:0] dado1, dado3;
  logic        we1, we3, bloq1, bloq3, busy1, busy3;
  logic        done1, done3, erro1, erro3;

  logic        sel;
  logic        obsWe, obsBloq, obsBusy, obsDone, obsErro;
  logic [5:0]  obsEnder;
  logic [31:0] obsDado;
  logic [3:0]  obsT;
  logic [5:0]  obsS;

  logic [9:0]  a1, a2;

  int testsRun;
  int testsFailed;

  // HD contents: a fixed tag in the top half plus the sector address.
  function automatic logic [31:0] hdModel(input logic [3:0] t, input logic [5:0] s);
    return {16'hC0DE, 6'd0, t, s};
  endfunction

  carregador_hd_mi #(.HD_LAT(1)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .start        (start1),
    .trilha_ini   (trilhaIni),
    .setor_ini    (setorIni),
    .dest_ini     (destIni),
    .num_palavras (numPalavras),
    .hd_trilha    (hdT1),
    .hd_setor     (hdS1),
    .hd_dado      (hdDado1),
    .mi_ender     (ender1),
    .mi_dado      (dado1),
    .mi_we        (we1),
    .bloq_cpu     (bloq1),
    .busy         (busy1),
    .done         (done1),
    .erro         (erro1)
  );

  carregador_hd_mi #(.HD_LAT(3)) dut3 (
    .clk          (clk),
    .reset        (reset),
    .start        (start3),
    .trilha_ini   (trilhaIni),
    .setor_ini    (setorIni),
    .dest_ini     (destIni),
    .num_palavras (numPalavras),
    .hd_trilha    (hdT3),
    .hd_setor     (hdS3),
    .hd_dado      (hdDado3),
    .mi_ender     (ender3),
    .mi_dado      (dado3),
    .mi_we        (we3),
    .bloq_cpu     (bloq3),
    .busy         (busy3),
    .done         (done3),
    .erro         (erro3)
  );

  // Latency-1 HD: data for the address presented in the current cycle.
  assign hdDado1 = hdModel(hdT1, hdS1);

  // Latency-3 HD: data reflects the address from two cycles back, so it is
  // correct only when sampled on the third edge after the address appeared.
  always @(posedge clk) begin
    a1 <= {hdT3, hdS3};
    a2 <= a1;
  end
  assign hdDado3 = hdModel(a2[9:6], a2[5:0]);

  // Observation mux selecting which instance the checks look at.
  always_comb begin
    obsWe    = sel ? we3    : we1;
    obsBloq  = sel ? bloq3  : bloq1;
    obsBusy  = sel ? busy3  : busy1;
    obsDone  = sel ? done3  : done1;
    obsErro  = sel ? erro3  : erro1;
    obsEnder = sel ? ender3 : ender1;
    obsDado  = sel ? dado3  : dado1;
    obsT     = sel ? hdT3   : hdT1;
    obsS     = sel ? hdS3   : hdS1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one start in a cycle, then scramble the request inputs (still a
  // valid request) so any late re-sampling would show up as extra activity.
  task automatic applyStimulus(input logic useLat3, input logic [3:0] t, input logic [5:0] s,
                               input logic [5:0] d, input logic [6:0] n);
    @(negedge clk);
    trilhaIni   = t;
    setorIni    = s;
    destIni     = d;
    numPalavras = n;
    if (useLat3) start3 = 1'b1;
    else         start1 = 1'b1;
    @(posedge clk);
    #1;
    start1      = 1'b0;
    start3      = 1'b0;
    trilhaIni   = 4'hF;
    setorIni    = 6'h2A;
    destIni     = 6'd1;
    numPalavras = 7'd5;
  endtask

  // Follows a transfer cycle by cycle from E0 (the edge leaving IDLE),
  // optionally pulsing start in chosen cycles, then checks the return to IDLE.
  task automatic checkTransfer(input string nome, input int lat, input logic [3:0] t,
                               input logic [5:0] s, input logic [5:0] d, input int n,
                               input logic [31:0] pulsos);
    int         total;
    int         i;
    logic [9:0] ts;
    logic       expWe;
    total = (lat + 1) * n;
    for (int k = 0; k <= total; k++) begin
      @(negedge clk);
      i     = k / (lat + 1);
      expWe = (k < total) && ((k % (lat + 1)) == lat);
      checkOutput($sformatf("%s k%0d we", nome, k), 32'(obsWe), 32'(expWe));
      if (expWe) begin
        ts = {t, s} + 10'(i);
        checkOutput($sformatf("%s k%0d ender", nome, k), 32'(obsEnder), 32'(d + 6'(i)));
        checkOutput($sformatf("%s k%0d dado", nome, k), obsDado, hdModel(ts[9:6], ts[5:0]));
      end
      checkOutput($sformatf("%s k%0d bloq", nome, k), 32'(obsBloq), 32'(k < total));
      checkOutput($sformatf("%s k%0d busy", nome, k), 32'(obsBusy), 32'(1));
      checkOutput($sformatf("%s k%0d done", nome, k), 32'(obsDone), 32'(k == total));
      checkOutput($sformatf("%s k%0d erro", nome, k), 32'(obsErro), 32'(0));
      if (sel) start3 = pulsos[k];
      else     start1 = pulsos[k];
    end
    @(negedge clk);
    checkOutput($sformatf("%s idle busy", nome), 32'(obsBusy), 32'(0));
    checkOutput($sformatf("%s idle done", nome), 32'(obsDone), 32'(0));
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  // A rejected request: erro for one cycle, never busy, never writing.
  task automatic checkReject(input string nome, input logic [5:0] d, input logic [6:0] n);
    @(negedge clk);
    destIni     = d;
    numPalavras = n;
    start1      = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    @(negedge clk);
    checkOutput({nome, " erro"}, 32'(obsErro), 32'(1));
    checkOutput({nome, " busy"}, 32'(obsBusy), 32'(0));
    checkOutput({nome, " we"},   32'(obsWe),   32'(0));
    checkOutput({nome, " done"}, 32'(obsDone), 32'(0));
    @(negedge clk);
    checkOutput({nome, " erro2"}, 32'(obsErro), 32'(0));
    checkOutput({nome, " busy2"}, 32'(obsBusy), 32'(0));
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    sel         = 1'b0;
    reset       = 1'b1;
    start1      = 1'b0;
    start3      = 1'b0;
    trilhaIni   = '0;
    setorIni    = '0;
    destIni     = '0;
    numPalavras = '0;
    a1          = '0;
    a2          = '0;

    // Reset state of both instances.
    repeat (2) @(negedge clk);
    checkOutput("rst we",    32'(we1),    32'(0));
    checkOutput("rst bloq",  32'(bloq1),  32'(0));
    checkOutput("rst busy",  32'(busy1),  32'(0));
    checkOutput("rst done",  32'(done1),  32'(0));
    checkOutput("rst erro",  32'(erro1),  32'(0));
    checkOutput("rst trilha",32'(hdT1),   32'(0));
    checkOutput("rst setor", 32'(hdS1),   32'(0));
    checkOutput("rst ender", 32'(ender1), 32'(0));
    checkOutput("rst dado",  dado1,       32'(0));
    checkOutput("rst busy3", 32'(busy3),  32'(0));
    reset = 1'b0;
    @(negedge clk);

    // Basic three-word load.
    applyStimulus(1'b0, 4'd2, 6'd5, 6'd10, 7'd3);
    checkTransfer("basic", 1, 4'd2, 6'd5, 6'd10, 3, 32'h0);

    // Sector wrap carries into the track.
    applyStimulus(1'b0, 4'd4, 6'd63, 6'd20, 7'd2);
    @(negedge clk);
    checkOutput("wrap addr0", {22'd0, obsT, obsS}, {22'd0, 4'd4, 6'd63});
    @(negedge clk);
    @(negedge clk);
    checkOutput("wrap addr1", {22'd0, obsT, obsS}, {22'd0, 4'd5, 6'd0});
    @(negedge clk);
    checkOutput("wrap ender1", 32'(obsEnder), 32'(21));
    checkOutput("wrap dado1",  obsDado, hdModel(4'd5, 6'd0));
    repeat (2) @(negedge clk);
    checkOutput("wrap idle", 32'(obsBusy), 32'(0));

    // Rejections and the accepted boundary case.
    checkReject("rej n0",   6'd10, 7'd0);
    checkReject("rej ovfl", 6'd60, 7'd5);
    applyStimulus(1'b0, 4'd1, 6'd0, 6'd60, 7'd4);
    checkTransfer("bound", 1, 4'd1, 6'd0, 6'd60, 4, 32'h0);

    // start pulsed in the first LER cycle and in FIM is ignored.
    applyStimulus(1'b0, 4'd1, 6'd1, 6'd0, 7'd2);
    checkTransfer("ignore", 1, 4'd1, 6'd1, 6'd0, 2, 32'h11);
    @(negedge clk);
    checkOutput("ignore idle2", 32'(obsBusy), 32'(0));

    // Asynchronous reset in the middle of an ESCREVE cycle.
    applyStimulus(1'b0, 4'd7, 6'd9, 6'd40, 7'd3);
    @(negedge clk);
    @(negedge clk);
    checkOutput("arst pre we", 32'(obsWe), 32'(1));
    #1 reset = 1'b1;
    #1;
    checkOutput("arst we",     32'(obsWe),   32'(0));
    checkOutput("arst bloq",   32'(obsBloq), 32'(0));
    checkOutput("arst busy",   32'(obsBusy), 32'(0));
    checkOutput("arst trilha", 32'(obsT),    32'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("arst done", 32'(obsDone), 32'(0));
    applyStimulus(1'b0, 4'd0, 6'd3, 6'd0, 7'd1);
    checkTransfer("fresh", 1, 4'd0, 6'd3, 6'd0, 1, 32'h0);

    // Three-cycle HD latency.
    sel = 1'b1;
    applyStimulus(1'b1, 4'd3, 6'd10, 6'd30, 7'd2);
    checkTransfer("lat3", 3, 4'd3, 6'd10, 6'd30, 2, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule : tb_carregador_hd_mi

// File: doc/carregador_hd_mi.md
Name: carregador_hd_mi

Overview:
- Loader that copies a block of words from the simulated HD into instruction memory (RAM) while the CPU is held.
- Sits beside the OS controller and is started by it. Drives HD trilha/setor addressing and the instruction-memory write port.
- Raises bloq_cpu for the whole transfer and pulses done at the end.

Parameters:
- DATA_W, 32, word width of HD data and instruction-memory data.
- ADDR_W, 6, instruction-memory address width (64 words).
- SETOR_W, 6, HD sector field width.
- TRILHA_W, 4, HD track field width.
- HD_LAT, 1, HD synchronous read latency in cycles (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request transfer; sampled only in IDLE
- trilha_ini  in  TRILHA_W  first HD track
- setor_ini  in  SETOR_W  first HD sector
- dest_ini  in  ADDR_W  first instruction-memory address
- num_palavras  in  ADDR_W+1  word count, 0..64
- hd_trilha  out  TRILHA_W  HD track address (registered)
- hd_setor  out  SETOR_W  HD sector address (registered)
- hd_dado  in  DATA_W  HD read data, valid HD_LAT cycles after address
- mi_ender  out  ADDR_W  instruction-memory write address
- mi_dado  out  DATA_W  instruction-memory write data
- mi_we  out  1  instruction-memory write enable
- bloq_cpu  out  1  hold CPU; high in LER and ESCREVE
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse, transfer complete
- erro  out  1  one-cycle pulse, request rejected

Behaviour:
- Reset (async): state IDLE. All outputs 0, including hd_trilha, hd_setor, mi_ender, mi_dado, mi_we, bloq_cpu, busy, done and erro. Internal counters are cleared.
- Reset mid-transfer: mi_we and bloq_cpu drop immediately. A partially written block stays in memory; no done pulse.
- States: IDLE, LER, ESCREVE, FIM.
- IDLE with start=1:
  - If num_palavras==0, or dest_ini+num_palavras>64: erro=1 for the next cycle, stay in IDLE, no HD or memory activity.
  - Otherwise latch trilha, setor, dest and remaining count. Load hd_trilha/hd_setor. Go to LER.
- LER: stays HD_LAT cycles (wait counter). On the last LER edge, capture hd_dado into the data buffer. Go to ESCREVE.
- ESCREVE: exactly one cycle with mi_we=1, mi_ender=current dest, mi_dado=buffer. At its end:
  - dest+1.
  - setor+1. On setor wrap from 2^SETOR_W-1 to 0, trilha+1 (trilha wraps modulo 2^TRILHA_W, no error).
  - remaining-1.
  - If remaining was 1, go to FIM; else go to LER with the new hd address.
- FIM: done=1, bloq_cpu=0, busy=1 for one cycle, then IDLE.
- Throughput: HD_LAT+1 cycles per word. With E0 as the edge leaving IDLE, word i (0-based) is written in cycle E0+(HD_LAT+1)*i+HD_LAT. done is high in cycle E0+(HD_LAT+1)*N.
- start outside IDLE is ignored and never queued. Input ports are don't-care after latching.
- start high in the FIM cycle is ignored. A new start is accepted in the following IDLE cycle at the earliest.
- mi_ender never exceeds 63; this is guaranteed by the start-time range check.
- done and erro are never high in the same cycle.

Decomposition:
- Shared package so_pkg:
  - state enum (IDLE, LER, ESCREVE, FIM);
  - widths DATA_W, ADDR_W, SETOR_W, TRILHA_W;
  - constant MI_PALAVRAS=64.
- One sub-module, contador_trilha_setor: loadable {trilha,setor} incrementer with sector-to-track carry. Inputs: load, inc, initial values. Outputs: current trilha/setor.
- The FSM and wait counter stay in carregador_hd_mi.

Test Plan:
- Basic load, HD_LAT=1, trilha=2, setor=5, dest=10, N=3, HD model returning {trilha,setor}:
  - mi_we high in cycles E0+1, E0+3, E0+5 with addresses 10, 11, 12 and data for setor 5, 6, 7;
  - done in E0+6;
  - bloq_cpu high E0..E0+5.
- Sector wrap, setor_ini=63, trilha_ini=4, N=2: second read at trilha=5, setor=0; writes to dest, dest+1.
- Rejections, each with erro pulse, no mi_we, busy stays 0:
  - num_palavras=0;
  - dest_ini=60 with N=5 (overflow).
  - Boundary dest_ini=60, N=4 is accepted; last write at address 63.
- start pulsed during LER and during FIM: ignored; exactly N writes; a single done pulse.
- Async reset asserted mid-ESCREVE: mi_we, bloq_cpu and busy drop without a clock edge. After release the block is IDLE and a fresh start completes normally.
- HD_LAT=3, N=2: writes at E0+3 and E0+7, done at E0+8; captured data matches the address presented three cycles earlier.
